// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per i_TX_DV request, LSB first, 8N1 framing.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high, waiting for i_TX_DV
// S_START  | start bit (line low) for CLKS_PER_BIT cycles
// S_DATA   | data bits 0..7, LSB first, CLKS_PER_BIT cycles each
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (line high); last cycle returns to idle with done pulse
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 217,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_TX_DV,
   input  logic [7:0] i_TX_Byte,
   output logic       o_TX_Active,
   output logic       o_TX_Serial,
   output logic       o_TX_Done
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`else
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
`endif

   logic [2:0]    state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    tx_byte;
   logic          cnt_wrap;

   assign cnt_wrap = (clk_cnt == CNT_LAST);

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state       <= S_IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         tx_byte     <= '0;
         o_TX_Serial <= 1'b1;
         o_TX_Active <= 1'b0;
         o_TX_Done   <= 1'b0;
      end else begin
         o_TX_Done <= 1'b0;
         case (state)
            S_IDLE: begin
               clk_cnt     <= '0;
               bit_idx     <= '0;
               o_TX_Serial <= 1'b1;
               if (i_TX_DV) begin
                  tx_byte     <= i_TX_Byte;
                  state       <= S_START;
                  o_TX_Serial <= 1'b0;
                  o_TX_Active <= 1'b1;
               end
            end

            S_START: begin
               if (cnt_wrap) begin
                  clk_cnt     <= '0;
                  state       <= S_DATA;
                  o_TX_Serial <= tx_byte[0];
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (cnt_wrap) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state       <= S_PARITY;
                     o_TX_Serial <= (^tx_byte) ^ PARITY_ODD;
`else
                     state       <= S_STOP;
                     o_TX_Serial <= 1'b1;
`endif
                  end else begin
                     bit_idx     <= bit_idx + 3'd1;
                     o_TX_Serial <= tx_byte[bit_idx + 3'd1];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (cnt_wrap) begin
                  clk_cnt     <= '0;
                  state       <= S_STOP;
                  o_TX_Serial <= 1'b1;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
`endif

            S_STOP: begin
               if (cnt_wrap) begin
                  // Done is raised as the FSM re-enters idle, so a request in the
                  // done cycle starts the next frame without an extra idle bit.
                  clk_cnt     <= '0;
                  state       <= S_IDLE;
                  o_TX_Done   <= 1'b1;
                  o_TX_Active <= 1'b0;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            default: begin
               state       <= S_IDLE;
               clk_cnt     <= '0;
               bit_idx     <= '0;
               o_TX_Serial <= 1'b1;
               o_TX_Active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer (CLKS_PER_BIT=4): stimulus pushes expected frames,
// a negedge monitor reconstructs each frame from the line and compares.
module tb_uart_tx_serializer;

   localparam int CPB     = 4;
   localparam bit TB_PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       i_Clk;
   logic       i_Reset;
   logic       i_TX_DV;
   logic [7:0] i_TX_Byte;
   logic       o_TX_Active;
   logic       o_TX_Serial;
   logic       o_TX_Done;

   typedef struct {
      logic [7:0] data;
      int         abort_at;
      bit         b2b;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   uart_tx_serializer #(
      .CLKS_PER_BIT(CPB),
      .PARITY_ODD  (TB_PODD)
   ) dut (
      .i_Clk      (i_Clk),
      .i_Reset    (i_Reset),
      .i_TX_DV    (i_TX_DV),
      .i_TX_Byte  (i_TX_Byte),
      .o_TX_Active(o_TX_Active),
      .o_TX_Serial(o_TX_Serial),
      .o_TX_Done  (o_TX_Done)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return (^d) ^ TB_PODD;
`endif
      return 1'b1;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge i_Clk);
      #1;
   endtask

   // Caller is 1 ns past a rising edge; returns 1 ns past the acceptance edge.
   task automatic send(input logic [7:0] d, input int abort_at, input bit b2b);
      exp_t e;
      e.data = d; e.abort_at = abort_at; e.b2b = b2b;
      sb_q.push_back(e);
      i_TX_DV   = 1'b1;
      i_TX_Byte = d;
      cycles(1);
      i_TX_DV   = 1'b0;
      i_TX_Byte = 8'h00;
   endtask

   task automatic wait_done();
      int k = 0;
      while (o_TX_Done !== 1'b1 && k < NBITS*CPB + 20) begin
         cycles(1);
         k++;
      end
      if (o_TX_Done !== 1'b1) check(1'b0, "done_timeout", 0, 1);
   endtask

   // Monitor
   initial begin : monitor
      exp_t e;
      int   ncyc     = 0;
      int   done_cyc = -10;
      int   bad;
      int   n;
      forever begin
         @(negedge i_Clk); ncyc++;
         if (o_TX_Serial === 1'b0) begin
            if (sb_q.size() == 0) begin
               check(1'b0, "unexpected_frame", 0, 1);
               repeat (NBITS*CPB + 1) begin @(negedge i_Clk); ncyc++; end
            end else begin
               e = sb_q.pop_front();
               if (e.b2b) check(ncyc == done_cyc + 1, "b2b_gap", ncyc - done_cyc, 1);
               bad = 0;
               n = (e.abort_at > 0) ? e.abort_at : NBITS*CPB;
               for (int i = 0; i < n; i++) begin
                  if (i > 0) begin @(negedge i_Clk); ncyc++; end
                  if (o_TX_Serial !== frame_bit(e.data, i / CPB) ||
                      o_TX_Active !== 1'b1 || o_TX_Done !== 1'b0) bad++;
               end
               check(bad == 0, $sformatf("frame_wave_%02h", e.data), bad, 0);
               @(negedge i_Clk); ncyc++;
               if (e.abort_at > 0) begin
                  check(o_TX_Serial === 1'b1 && o_TX_Active === 1'b0 && o_TX_Done === 1'b0,
                        "abort_idle", {o_TX_Serial, o_TX_Active, o_TX_Done}, 3'b100);
                  bad = 0;
                  repeat (12) begin
                     @(negedge i_Clk); ncyc++;
                     if (o_TX_Serial !== 1'b1 || o_TX_Done !== 1'b0) bad++;
                  end
                  check(bad == 0, "abort_quiet", bad, 0);
               end else begin
                  check(o_TX_Done === 1'b1 && o_TX_Active === 1'b0 && o_TX_Serial === 1'b1,
                        $sformatf("done_pulse_%02h", e.data),
                        {o_TX_Serial, o_TX_Active, o_TX_Done}, 3'b101);
                  done_cyc = ncyc;
               end
            end
         end
      end
   end

   // Stimulus
   initial begin : stim
      i_Reset   = 1'b1;
      i_TX_DV   = 1'b0;
      i_TX_Byte = 8'h00;
      cycles(3);
      check(o_TX_Serial === 1'b1, "reset_serial", o_TX_Serial, 1);
      check(o_TX_Active === 1'b0, "reset_active", o_TX_Active, 0);
      check(o_TX_Done   === 1'b0, "reset_done",   o_TX_Done,   0);
      i_Reset = 1'b0;
      cycles(2);

      send(8'h55, -1, 1'b0);
      wait_done();
      cycles(5);

      // Request during an active frame must be ignored
      send(8'hA3, -1, 1'b0);
      cycles(9);
      i_TX_DV   = 1'b1;
      i_TX_Byte = 8'hFF;
      cycles(1);
      i_TX_DV   = 1'b0;
      i_TX_Byte = 8'h00;
      wait_done();
      cycles(5);

      send(8'h81, -1, 1'b0);
      wait_done();
      send(8'h0F, -1, 1'b1);
      wait_done();
      cycles(5);

      // Reset sampled 17 edges after acceptance
      send(8'h3C, 17, 1'b0);
      cycles(16);
      i_Reset = 1'b1;
      cycles(1);
      i_Reset = 1'b0;
      cycles(25);

      send(8'h00, -1, 1'b0);
      wait_done();
      cycles(3);
      send(8'h07, -1, 1'b0);
      wait_done();
      cycles(3);
      send(8'hFF, -1, 1'b0);
      wait_done();
      cycles(10);

      check(sb_q.size() == 0, "queue_drained", sb_q.size(), 0);
      check(o_TX_Serial === 1'b1 && o_TX_Active === 1'b0, "final_idle",
            {o_TX_Serial, o_TX_Active}, 2'b10);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
